aig_mix_bist: RTL and testbench

Built-in self-test harness for the combinational `aig_mix` benchmark cores. It drives the core's 96-bit input vector with a maximal-length LFSR pattern sequence, compacts the 48-bit response into a MISR signature, and compares that signature against a golden value. It sits around a benchmark instance in the synthetic test wrappers and gives those cores a sequential source and sink.

---
 rtl/aig_mix_bist_pkg.sv | 39 +++
 rtl/aig_mix_misr.sv | 36 +++
 rtl/aig_mix_bist.sv | 132 +++++++++++++
 tb/tb_aig_mix_bist.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/aig_mix_bist_pkg.sv
// Shared types, widths and tap positions for the aig_mix BIST harness.
// The LFSR and MISR step functions live here so the top and MISR agree on taps.
package aig_mix_bist_pkg;

    localparam int LFSR_W = 96;
    localparam int MISR_W = 48;
    localparam int CNT_W  = 16;

    localparam int LFSR_TAP_A = 95;
    localparam int LFSR_TAP_B = 93;
    localparam int LFSR_TAP_C = 48;
    localparam int LFSR_TAP_D = 46;

    localparam int MISR_TAP_A = 47;
    localparam int MISR_TAP_B = 46;
    localparam int MISR_TAP_C = 20;
    localparam int MISR_TAP_D = 19;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D];
        return {s[LFSR_W-2:0], fb};
    endfunction

    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] g,
                                                    input logic [MISR_W-1:0] r);
        logic f;
        f = g[MISR_TAP_A] ^ g[MISR_TAP_B] ^ g[MISR_TAP_C] ^ g[MISR_TAP_D];
        return {g[MISR_W-2:0], f} ^ r;
    endfunction

endpackage

// File: rtl/aig_mix_misr.sv
// 48-bit multiple-input signature register with enable and synchronous clear.
module aig_mix_misr
    import aig_mix_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [MISR_W-1:0] resp_in,
    output logic [MISR_W-1:0] sig_out
);

    logic [MISR_W-1:0] sig_q, sig_d;

    // NOTE: sig_d is given its hold value first so every path assigns it and no latch is inferred.
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = misr_step(sig_q, resp_in);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_out = sig_q;

endmodule

// File: rtl/aig_mix_bist.sv
// BIST harness: LFSR pattern source, valid pipe matching the core latency,
// MISR response compaction and golden-signature compare.
module aig_mix_bist
    import aig_mix_bist_pkg::*;
#(
    parameter int              IN_W     = 96,
    parameter int              OUT_W    = 48,
    parameter int              PATTERNS = 1024,
    parameter logic [IN_W-1:0] SEED     = 96'h1,
    parameter int              DUT_LAT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OUT_W-1:0] golden,
    input  logic [OUT_W-1:0] resp_in,
    output logic [IN_W-1:0]  pat_out,
    output logic [OUT_W-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    if (IN_W != LFSR_W || OUT_W != MISR_W) begin : g_bad_width
        $error("aig_mix_bist: IN_W must be 96 and OUT_W must be 48");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("aig_mix_bist: SEED must be nonzero");
    end
    if (PATTERNS < 1 || PATTERNS > 65535) begin : g_bad_patterns
        $error("aig_mix_bist: PATTERNS must be 1..65535");
    end
    if (DUT_LAT < 0 || DUT_LAT > 3) begin : g_bad_lat
        $error("aig_mix_bist: DUT_LAT must be 0..3");
    end

    localparam logic [CNT_W-1:0] LAST_PAT   = CNT_W'(PATTERNS - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

    state_t            state_q, state_d;
    logic [IN_W-1:0]   lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              issue;
    logic              misr_clr;
    logic              compact_en;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        count_d  = count_q;
        issue    = 1'b0;
        misr_clr = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    lfsr_d   = SEED;
                    count_d  = '0;
                    misr_clr = 1'b1;
                end
            end
            ST_RUN: begin
                issue   = 1'b1;
                count_d = count_q + 1'b1;
                // The final pattern stays on pat_out instead of stepping past it.
                if (count_q == LAST_PAT) begin
                    count_d = '0;
                    state_d = (DUT_LAT == 0) ? ST_DONE : ST_FLUSH;
                end else begin
                    lfsr_d = lfsr_step(lfsr_q);
                end
            end
            ST_FLUSH: begin
                count_d = count_q + 1'b1;
                if (count_q == LAST_FLUSH) begin
                    count_d = '0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
        end
    end

    // Compaction lines up with the core's response: issue delayed by DUT_LAT cycles.
    if (DUT_LAT == 0) begin : g_vld_none
        assign compact_en = issue;
    end else begin : g_vld_pipe
        logic [DUT_LAT-1:0] vld_q, vld_d;

        always_comb begin
            vld_d    = vld_q << 1;
            vld_d[0] = issue;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
            end else begin
                vld_q <= vld_d;
            end
        end

        assign compact_en = vld_q[DUT_LAT-1];
    end

    aig_mix_misr u_misr (
        .clk     (clk),
        .rst     (rst),
        .clr     (misr_clr),
        .en      (compact_en),
        .resp_in (resp_in),
        .sig_out (signature)
    );

    assign pat_out = lfsr_q;
    assign busy    = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done    = (state_q == ST_DONE);
    assign pass    = done && (signature == golden);

endmodule

// File: tb/tb_aig_mix_bist.sv
// Directed bench for aig_mix_bist: four instances cover the LFSR sequence,
// loopback signatures, tap feedback, core latency, start-while-busy, reset and restart.
module tb_aig_mix_bist;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: SEED=1, PATTERNS=4, DUT_LAT=0; response tied 0 or looped back.
    logic        start_a, loop_a;
    logic [47:0] golden_a, resp_a, sig_a;
    logic [95:0] pat_a;
    logic        busy_a, done_a, pass_a;
    assign resp_a = loop_a ? pat_a[47:0] : 48'h0;

    aig_mix_bist #(.PATTERNS(4), .SEED(96'h1), .DUT_LAT(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .golden(golden_a), .resp_in(resp_a),
        .pat_out(pat_a), .signature(sig_a), .busy(busy_a), .done(done_a), .pass(pass_a)
    );

    // Instance B: SEED=1, PATTERNS=3, DUT_LAT=0, loopback.
    logic        start_b;
    logic [47:0] golden_b, sig_b;
    logic [95:0] pat_b;
    logic        busy_b, done_b, pass_b;

    aig_mix_bist #(.PATTERNS(3), .SEED(96'h1), .DUT_LAT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .golden(golden_b), .resp_in(pat_b[47:0]),
        .pat_out(pat_b), .signature(sig_b), .busy(busy_b), .done(done_b), .pass(pass_b)
    );

    // Instance C: SEED=1<<95, PATTERNS=2, response driven directly.
    logic        start_c;
    logic [47:0] golden_c, resp_c, sig_c;
    logic [95:0] pat_c;
    logic        busy_c, done_c, pass_c;

    aig_mix_bist #(.PATTERNS(2), .SEED(96'h1 << 95), .DUT_LAT(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .golden(golden_c), .resp_in(resp_c),
        .pat_out(pat_c), .signature(sig_c), .busy(busy_c), .done(done_c), .pass(pass_c)
    );

    // Instance D: PATTERNS=3, DUT_LAT=2, core modelled as two register stages.
    logic        start_d;
    logic [47:0] golden_d, sig_d, core_r1, core_r2;
    logic [95:0] pat_d;
    logic        busy_d, done_d, pass_d;

    always @(posedge clk) begin
        core_r1 <= pat_d[47:0];
        core_r2 <= core_r1;
    end

    aig_mix_bist #(.PATTERNS(3), .SEED(96'h1), .DUT_LAT(2)) dut_d (
        .clk(clk), .rst(rst), .start(start_d), .golden(golden_d), .resp_in(core_r2),
        .pat_out(pat_d), .signature(sig_d), .busy(busy_d), .done(done_d), .pass(pass_d)
    );

    typedef struct {
        logic        start;
        logic        chk_pat;
        logic [95:0] pat;
        logic [47:0] sig;
        logic        busy;
        logic        done;
        logic        pass;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        start_c  = 1'b0;
        start_d  = 1'b0;
        loop_a   = 1'b0;
        resp_c   = 48'h0;
        golden_a = 48'h0;
        golden_b = 48'h4;
        golden_c = 48'h1;
        golden_d = 48'h4;
        tick();
        tick();
        rst = 1'b0;

        // LFSR sequence with response tied 0; entry 0 is the post-reset IDLE cycle.
        //         start chk  pat      sig    busy  done  pass
        tbl[0] = '{1'b1, 1'b1, 96'h1, 48'h0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 96'h1, 48'h0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 96'h2, 48'h0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 96'h4, 48'h0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 96'h8, 48'h0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 96'h0, 48'h0, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 96'h0, 48'h0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            start_a = tbl[i].start;
            if (tbl[i].chk_pat) check($sformatf("seq[%0d] pat_out", i), pat_a, tbl[i].pat);
            check($sformatf("seq[%0d] signature", i), 96'(sig_a), 96'(tbl[i].sig));
            check($sformatf("seq[%0d] busy", i), 96'(busy_a), 96'(tbl[i].busy));
            check($sformatf("seq[%0d] done", i), 96'(done_a), 96'(tbl[i].done));
            check($sformatf("seq[%0d] pass", i), 96'(pass_a), 96'(tbl[i].pass));
            tick();
        end
        start_a = 1'b0;

        // Loopback, 4 patterns: signature 4 after three compactions, 0 after four.
        loop_a  = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        tick();
        check("loop4 mid signature", 96'(sig_a), 96'h4);
        tick();
        check("loop4 done", 96'(done_a), 96'h1);
        check("loop4 signature", 96'(sig_a), 96'h0);

        // Loopback, 3 patterns, golden compare.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("loop3 first pat", pat_b, 96'h1);
        tick();
        tick();
        check("loop3 not yet done", 96'(done_b), 96'h0);
        tick();
        check("loop3 done", 96'(done_b), 96'h1);
        check("loop3 signature", 96'(sig_b), 96'h4);
        check("loop3 pass golden 4", 96'(pass_b), 96'h1);
        golden_b = 48'h5;
        #1;
        check("loop3 pass golden 5", 96'(pass_b), 96'h0);
        golden_b = 48'h4;

        // Restart from DONE, with a start pulse in RUN cycle 2 that must be ignored.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("restart done cleared", 96'(done_b), 96'h0);
        check("restart pass cleared", 96'(pass_b), 96'h0);
        check("restart busy", 96'(busy_b), 96'h1);
        check("restart pat", pat_b, 96'h1);
        check("restart sig cleared", 96'(sig_b), 96'h0);
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("busy start pat cycle 3", pat_b, 96'h4);
        check("busy start still busy", 96'(busy_b), 96'h1);
        tick();
        check("busy start done", 96'(done_b), 96'h1);
        check("busy start signature", 96'(sig_b), 96'h4);
        check("busy start pass", 96'(pass_b), 96'h1);

        // Reset in RUN cycle 3, then a fresh run.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset busy", 96'(busy_b), 96'h0);
        check("reset done", 96'(done_b), 96'h0);
        check("reset pat", pat_b, 96'h1);
        check("reset signature", 96'(sig_b), 96'h0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("after reset pat", pat_b, 96'h1);
        tick();
        tick();
        tick();
        check("after reset done", 96'(done_b), 96'h1);
        check("after reset signature", 96'(sig_b), 96'h4);

        // Feedback taps: LFSR top bit wraps to bit 0; MISR bit 47 wraps to bit 0.
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        check("tap first pat", pat_c, 96'h1 << 95);
        resp_c = 48'h1 << 47;
        tick();
        check("tap second pat", pat_c, 96'h1);
        check("tap misr preload", 96'(sig_c), 96'(48'h1 << 47));
        resp_c = 48'h0;
        tick();
        check("tap done", 96'(done_c), 96'h1);
        check("tap misr feedback", 96'(sig_c), 96'h1);

        // Two-cycle core latency: busy cycles 1..5, done in cycle 6, same signature.
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("lat2 busy c%0d", c), 96'(busy_d), 96'(c <= 5));
            check($sformatf("lat2 done c%0d", c), 96'(done_d), 96'(c == 6));
            if (c < 6) tick();
        end
        check("lat2 signature", 96'(sig_d), 96'h4);
        check("lat2 pass", 96'(pass_d), 96'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
